// File: rtl/reg_alu_pkg.sv
// Shared definitions for the register/ALU core: opcode and FSM state
// enumerations plus the opcode field width.
package reg_alu_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_MOV = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_INC = 4'h6,
    OP_DEC = 4'h7,
    OP_SHL = 4'h8,
    OP_SHR = 4'h9,
    OP_ADC = 4'hA,
    OP_SBB = 4'hB
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/reg_alu_unit.sv
// Combinational ALU: produces a DATA_W+1 bit result whose top bit is the
// carry (additions, shifts) or borrow (subtractions) for that opcode.
module reg_alu_unit
  import reg_alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_carry_in,
  input  logic [OPC_W-1:0]  i_opcode,
  output logic [DATA_W:0]   o_result,
  output logic              o_carry_out,
  output logic              o_writes_carry,
  output logic              o_is_reserved
);

  logic [DATA_W:0] w_a;
  logic [DATA_W:0] w_b;
  logic [DATA_W:0] w_cin;

  assign w_a   = {1'b0, i_a};
  assign w_b   = {1'b0, i_b};
  assign w_cin = {{DATA_W{1'b0}}, i_carry_in};

  // Opcode decode; subtraction in DATA_W+1 bits leaves the borrow in the MSB.
  always_comb begin
    o_result       = {(DATA_W+1){1'b0}};
    o_writes_carry = 1'b1;
    o_is_reserved  = 1'b0;
    case (opcode_e'(i_opcode))
      OP_MOV: begin
        o_result       = w_b;
        o_writes_carry = 1'b0;
      end
      OP_ADD: o_result = w_a + w_b;
      OP_SUB: o_result = w_a - w_b;
      OP_AND: begin
        o_result       = w_a & w_b;
        o_writes_carry = 1'b0;
      end
      OP_OR: begin
        o_result       = w_a | w_b;
        o_writes_carry = 1'b0;
      end
      OP_XOR: begin
        o_result       = w_a ^ w_b;
        o_writes_carry = 1'b0;
      end
      OP_INC: o_result = w_a + (DATA_W+1)'(1);
      OP_DEC: o_result = w_a - (DATA_W+1)'(1);
      OP_SHL: o_result = {i_a, 1'b0};
      OP_SHR: o_result = {i_a[0], 1'b0, i_a[DATA_W-1:1]};
      OP_ADC: o_result = w_a + w_b + w_cin;
      OP_SBB: o_result = w_a - w_b - w_cin;
      default: begin
        o_writes_carry = 1'b0;
        o_is_reserved  = 1'b1;
      end
    endcase
  end

  assign o_carry_out = o_result[DATA_W];

endmodule

// File: rtl/reg_alu_core.sv
// Four-stage (IDLE/READ/EXEC/WB) register-file ALU core; register 0 is a
// read-only count of retired instructions.
module reg_alu_core
  import reg_alu_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NREGS   = 4,
  localparam int REG_W   = $clog2(NREGS),
  localparam int INSTR_W = OPC_W + 2 * REG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  out_reg,
  output logic               flag_zero,
  output logic               flag_carry,
  output logic               illegal,
  output logic               retired
);

  state_e             r_state;
  state_e             w_next_state;
  logic [INSTR_W-1:0] r_instr;
  logic [DATA_W-1:0]  r_regs [NREGS];
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W-1:0]  r_result;
  logic               r_res_carry;
  logic               r_res_wc;
  logic               r_res_rsv;
  logic               r_zero;
  logic               r_carry;
  logic               r_illegal;
  logic               r_retired;

  logic [OPC_W-1:0]   w_opcode;
  logic [REG_W-1:0]   w_dst;
  logic [REG_W-1:0]   w_src;
  logic               w_hs;
  logic [DATA_W:0]    w_alu_result;
  logic               w_alu_carry;
  logic               w_alu_wc;
  logic               w_alu_rsv;

  assign w_opcode = r_instr[INSTR_W-1 -: OPC_W];
  assign w_dst    = r_instr[2*REG_W-1 -: REG_W];
  assign w_src    = r_instr[REG_W-1:0];
  assign w_hs     = instr_valid && (r_state == ST_IDLE);

  reg_alu_unit #(.DATA_W(DATA_W)) u_alu (
    .i_a           (r_a),
    .i_b           (r_b),
    .i_carry_in    (r_carry),
    .i_opcode      (w_opcode),
    .o_result      (w_alu_result),
    .o_carry_out   (w_alu_carry),
    .o_writes_carry(w_alu_wc),
    .o_is_reserved (w_alu_rsv)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; valid outside IDLE is simply not looked at.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          w_next_state = ST_READ;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_READ: w_next_state = ST_EXEC;
      ST_EXEC: w_next_state = ST_WB;
      ST_WB:   w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: capture, operand read, result latch and write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs[0] <= {DATA_W{1'b0}};
      for (int i = 1; i < NREGS; i++) begin
        r_regs[i] <= DATA_W'(i);
      end
      r_instr     <= {INSTR_W{1'b0}};
      r_a         <= {DATA_W{1'b0}};
      r_b         <= {DATA_W{1'b0}};
      r_result    <= {DATA_W{1'b0}};
      r_res_carry <= 1'b0;
      r_res_wc    <= 1'b0;
      r_res_rsv   <= 1'b0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_illegal   <= 1'b0;
      r_retired   <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      r_retired <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_instr <= instr;
          end
        end
        ST_READ: begin
          r_a <= r_regs[w_dst];
          r_b <= r_regs[w_src];
        end
        ST_EXEC: begin
          r_result    <= w_alu_result[DATA_W-1:0];
          r_res_carry <= w_alu_carry;
          r_res_wc    <= w_alu_wc;
          r_res_rsv   <= w_alu_rsv;
        end
        ST_WB: begin
          if (r_res_rsv) begin
            r_illegal <= 1'b1;
          end else begin
            // Counter bumps on every retire; a dst=0 result is dropped.
            r_regs[0] <= r_regs[0] + DATA_W'(1);
            if (w_dst != {REG_W{1'b0}}) begin
              r_regs[w_dst] <= r_result;
            end
            r_zero <= (r_result == {DATA_W{1'b0}});
            if (r_res_wc) begin
              r_carry <= r_res_carry;
            end
            r_retired <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_ready = (r_state == ST_IDLE);
  assign out_reg     = r_regs[NREGS-1];
  assign flag_zero   = r_zero;
  assign flag_carry  = r_carry;
  assign illegal     = r_illegal;
  assign retired     = r_retired;

endmodule

// File: tb/tb_reg_alu_core.sv
// Self-checking bench for reg_alu_core (DATA_W=8, NREGS=4): directed
// scenarios plus random instructions against an integer reference model.
module tb_reg_alu_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] out_reg;
  logic       flag_zero;
  logic       flag_carry;
  logic       illegal;
  logic       retired;

  int n_vec = 0;
  int n_err = 0;
  int m_regs [4];
  int m_zero;
  int m_carry;

  reg_alu_core #(.DATA_W(8), .NREGS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .out_reg    (out_reg),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .illegal    (illegal),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = i;
    m_zero  = 0;
    m_carry = 0;
  endtask

  // Reference semantics in plain integer arithmetic.
  task automatic model_exec(input logic [7:0] ins, output bit ill);
    int op, d, s, a, b, r;
    bit wc;
    op = int'(ins[7:4]);
    d  = int'(ins[3:2]);
    s  = int'(ins[1:0]);
    a  = m_regs[d];
    b  = m_regs[s];
    wc = 1'b1;
    ill = 1'b0;
    r = 0;
    case (op)
      0:  begin r = b;     wc = 1'b0; end
      1:  r = a + b;
      2:  r = a - b;
      3:  begin r = a & b; wc = 1'b0; end
      4:  begin r = a | b; wc = 1'b0; end
      5:  begin r = a ^ b; wc = 1'b0; end
      6:  r = a + 1;
      7:  r = a - 1;
      8:  r = a * 2;
      9:  r = a / 2;
      10: r = a + b + m_carry;
      11: r = a - b - m_carry;
      default: ill = 1'b1;
    endcase
    if (!ill) begin
      if (wc) begin
        if (op == 9) m_carry = a % 2;
        else         m_carry = (r < 0 || r > 255) ? 1 : 0;
      end
      r = (r + 512) % 256;
      m_zero = (r == 0) ? 1 : 0;
      m_regs[0] = (m_regs[0] + 1) % 256;
      if (d != 0) m_regs[d] = r;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic issue(input logic [7:0] ins);
    logic [31:0] old3;
    bit ill;
    @(negedge clk);
    for (int t = 0; t < 8 && instr_ready !== 1'b1; t++) @(negedge clk);
    chk("ready_idle", 32'(instr_ready), 32'd1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("ready_busy", 32'(instr_ready), 32'd0);
    old3 = 32'(m_regs[3]);
    repeat (2) @(posedge clk);
    #1;
    chk("wb_no_early_write", 32'(out_reg), old3);
    chk("wb_no_early_retire", 32'(retired), 32'd0);
    model_exec(ins, ill);
    @(posedge clk); #1;
    chk("out_reg", 32'(out_reg), 32'(m_regs[3]));
    chk("flag_zero", 32'(flag_zero), 32'(m_zero));
    chk("flag_carry", 32'(flag_carry), 32'(m_carry));
    chk("retired", 32'(retired), ill ? 32'd0 : 32'd1);
    chk("illegal", 32'(illegal), ill ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    chk("retired_pulse_end", 32'(retired), 32'd0);
    chk("illegal_pulse_end", 32'(illegal), 32'd0);
  endtask

  initial begin
    bit ill;
    logic [7:0] ins;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 8'h00;
    model_reset();

    // Reset state and the first ADD.
    do_reset();
    #1;
    chk("rst_out_reg", 32'(out_reg), 32'h03);
    chk("rst_zero", 32'(flag_zero), 32'd0);
    chk("rst_carry", 32'(flag_carry), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    issue(8'h1E);
    chk("add_result", 32'(out_reg), 32'h05);
    issue(8'h0C);
    chk("counter_after_one", 32'(out_reg), 32'h01);

    // SUB borrow, ADC wrap with carry, XOR self to zero.
    do_reset();
    issue(8'h26);
    chk("sub_carry", 32'(flag_carry), 32'd1);
    issue(8'hA5);
    chk("adc_carry", 32'(flag_carry), 32'd1);
    issue(8'h0D);
    chk("adc_result", 32'(out_reg), 32'hFF);
    issue(8'h5A);
    chk("xor_zero", 32'(flag_zero), 32'd1);
    chk("xor_keeps_carry", 32'(flag_carry), 32'd1);
    issue(8'h0E);
    chk("xor_result", 32'(out_reg), 32'h00);

    // Reserved opcode, then MOV into the counter register.
    do_reset();
    issue(8'hF7);
    chk("illegal_keeps_reg3", 32'(out_reg), 32'h03);
    issue(8'h01);
    issue(8'h0C);
    chk("counter_after_mov0", 32'(out_reg), 32'h01);

    // Valid held high across two instructions.
    do_reset();
    @(negedge clk);
    instr = 8'h1F;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr = 8'h6C;
    chk("hold_ready_n1", 32'(instr_ready), 32'd0);
    @(posedge clk); #1;
    chk("hold_ready_n2", 32'(instr_ready), 32'd0);
    @(posedge clk); #1;
    chk("hold_ready_n3", 32'(instr_ready), 32'd0);
    @(posedge clk); #1;
    chk("hold_ready_n4", 32'(instr_ready), 32'd1);
    model_exec(8'h1F, ill);
    chk("hold_first_result", 32'(out_reg), 32'(m_regs[3]));
    @(posedge clk); #1;
    chk("hold_second_taken", 32'(instr_ready), 32'd0);
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_exec(8'h6C, ill);
    chk("hold_second_result", 32'(out_reg), 32'(m_regs[3]));
    chk("hold_second_retired", 32'(retired), 32'd1);
    @(posedge clk); #1;
    chk("hold_no_duplicate", 32'(retired), 32'd0);
    chk("hold_idle", 32'(instr_ready), 32'd1);

    // Reset while the ADD is in EXEC.
    do_reset();
    @(negedge clk);
    instr = 8'h1E;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_reg", 32'(out_reg), 32'h03);
    chk("abort_no_retire", 32'(retired), 32'd0);
    chk("abort_idle", 32'(instr_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("abort_still_no_retire", 32'(retired), 32'd0);
    chk("abort_out_reg_kept", 32'(out_reg), 32'h03);

    // Random instructions, with occasional MOVs exposing the destination.
    do_reset();
    for (int k = 0; k < 60; k++) begin
      ins = 8'($urandom);
      issue(ins);
      if ($urandom_range(1, 0) == 1) issue({4'h0, 2'd3, ins[3:2]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
